// File: rtl/audio_sfx_sequencer.sv
// ---------------------------------------------------------------------------
// audio_sfx_sequencer
//
// Plays short 8-bit unsigned sound-effect clips from a synchronous sample ROM
// and hands them to a codec as 16-bit signed samples at a fixed sample rate.
// Trigger requests are remembered in a pending register. The lowest-numbered
// pending clip plays first. A lower-numbered request can cut off a clip that
// is already playing.
//
// Ports
//   i_clk            single rising-edge clock
//   i_reset          asynchronous active-high reset
//   i_trigger        one-cycle request pulse per clip
//   o_rom_addr       registered address to the 1-cycle-latency sample ROM
//   i_rom_q          unsigned ROM data, valid the cycle after o_rom_addr
//   o_sample         signed 16-bit sample to the codec
//   o_sample_valid   o_sample holds a sample not yet accepted
//   i_sample_ready   codec accepts o_sample when high with o_sample_valid
//   o_busy           a clip is playing
//   o_active_id      index of the clip that is playing
//   o_done           one-cycle pulse on bit i when clip i's last sample is taken
//   o_underrun       one-cycle pulse when a sample tick arrives too early
// ---------------------------------------------------------------------------
module audio_sfx_sequencer #(
    parameter int NUM_SFX = 4,
    parameter int CLK_DIV = 6250,
    parameter logic [18*NUM_SFX-1:0] SFX_START = {18'h18000, 18'h0C000, 18'h06000, 18'h00000},
    parameter logic [18*NUM_SFX-1:0] SFX_END   = {18'h23FFF, 18'h17FFF, 18'h0BFFF, 18'h05FFF},
    localparam int ID_W  = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1,
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_SFX-1:0] i_trigger,
    output logic [17:0]        o_rom_addr,
    input  logic [7:0]         i_rom_q,
    output logic [15:0]        o_sample,
    output logic               o_sample_valid,
    input  logic               i_sample_ready,
    output logic               o_busy,
    output logic [ID_W-1:0]    o_active_id,
    output logic [NUM_SFX-1:0] o_done,
    output logic               o_underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PACE,
        S_FETCH,
        S_READ,
        S_OUT
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_tickCnt;
    logic [NUM_SFX-1:0] r_pending;
    logic [17:0]        r_curAddr;
    logic [17:0]        r_romAddr;
    logic [15:0]        r_sample;
    logic               r_sampleValid;
    logic               r_busy;
    logic [ID_W-1:0]    r_activeId;
    logic [NUM_SFX-1:0] r_done;
    logic               r_underrun;

    logic               w_tick;
    logic [ID_W-1:0]    w_sel;
    logic               w_anyPending;
    logic               w_accept;
    logic               w_atEnd;
    logic               w_preempt;
    logic               w_start;
    logic [17:0]        w_selStart;
    logic [NUM_SFX-1:0] w_clearMask;

    // Free-running sample-rate divider. The tick is the last count of each
    // period, so the first tick comes CLK_DIV cycles after reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + CNT_W'(1);
        end
    end

    assign w_tick = (r_tickCnt == CNT_W'(CLK_DIV - 1));

    // Arbitration and start decisions. The loop runs from the top index down,
    // so the lowest pending index is the one left in w_sel. A preemption
    // happens only at a sample acceptance. It needs a strictly lower pending
    // index, so the active clip can never preempt itself. On the last sample
    // of a clip the clip ends normally with done, and the IDLE state then
    // picks up whatever is pending.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_SFX - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = ID_W'(i);
            end
        end
        w_anyPending = |r_pending;
        w_accept     = (r_state == S_OUT) && r_sampleValid && i_sample_ready;
        w_atEnd      = (r_curAddr == SFX_END[int'(r_activeId)*18 +: 18]);
        w_preempt    = w_accept && !w_atEnd && w_anyPending && (w_sel < r_activeId);
        w_start      = ((r_state == S_IDLE) && w_anyPending) || w_preempt;
        w_selStart   = SFX_START[int'(w_sel)*18 +: 18];
        w_clearMask  = '0;
        if (w_start) begin
            w_clearMask[w_sel] = 1'b1;
        end
    end

    // Pending requests. New triggers are ORed in after the clear, so a request
    // that arrives in the same cycle its clip starts is kept. That request
    // replays the clip once the current pass ends.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clearMask) | i_trigger;
        end
    end

    // Playback state machine. One sample is fetched per tick: the address
    // goes out in PACE, the ROM responds during FETCH, and the data is
    // captured in READ. The sample is then held in OUT until the codec takes
    // it. A tick that lands while a sample is still in flight is not acted
    // on; it is only flagged as an underrun, so no ROM address is skipped.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_curAddr     <= '0;
            r_romAddr     <= '0;
            r_sample      <= '0;
            r_sampleValid <= 1'b0;
            r_busy        <= 1'b0;
            r_activeId    <= '0;
            r_done        <= '0;
            r_underrun    <= 1'b0;
        end else begin
            r_done     <= '0;
            r_underrun <= w_tick && ((r_state == S_FETCH) || (r_state == S_READ) || (r_state == S_OUT));
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_curAddr  <= w_selStart;
                        r_activeId <= w_sel;
                        r_busy     <= 1'b1;
                        r_state    <= S_PACE;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_PACE: begin
                    if (w_tick) begin
                        r_romAddr <= r_curAddr;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_READ;
                end
                S_READ: begin
                    r_sample      <= {i_rom_q ^ 8'h80, 8'h00};
                    r_sampleValid <= 1'b1;
                    r_state       <= S_OUT;
                end
                S_OUT: begin
                    if (w_accept) begin
                        r_sampleValid <= 1'b0;
                        if (w_preempt) begin
                            r_curAddr  <= w_selStart;
                            r_activeId <= w_sel;
                            r_state    <= S_PACE;
                        end else if (w_atEnd) begin
                            r_done[r_activeId] <= 1'b1;
                            r_busy             <= w_anyPending || (|i_trigger);
                            r_state            <= S_IDLE;
                        end else begin
                            r_curAddr <= r_curAddr + 18'd1;
                            r_state   <= S_PACE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rom_addr     = r_romAddr;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_sampleValid;
    assign o_busy         = r_busy;
    assign o_active_id    = r_activeId;
    assign o_done         = r_done;
    assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_audio_sfx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_audio_sfx_sequencer
//
// Drives audio_sfx_sequencer with four small clips held in a behavioural ROM.
// Every codec handshake is recorded. The recorded sample stream is compared
// with the clip sequence that the playback rules predict.
// ---------------------------------------------------------------------------
module tb_audio_sfx_sequencer;

    localparam int NUM_SFX = 4;
    localparam int CLK_DIV = 4;

    typedef struct {
        logic [15:0] s;
        logic [1:0]  id;
        int          cyc;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  trigger;
    logic [17:0] romAddr;
    logic [7:0]  romQ;
    logic [15:0] sample;
    logic        sampleValid;
    logic        sampleReady;
    logic        busy;
    logic [1:0]  activeId;
    logic [3:0]  done;
    logic        underrun;

    logic [7:0]  mem [64];
    int          clipStart [4] = '{0, 16, 32, 48};
    int          clipEnd   [4] = '{2, 20, 39, 48};

    acc_t        accQ[$];
    acc_t        expQ[$];
    int          cycle = 0;
    int          doneCount [4] = '{0, 0, 0, 0};
    int          doneBase  [4];
    int          stableErr = 0;
    logic        holdPending = 1'b0;
    logic [15:0] heldSample = '0;

    int          nAsserts;
    int          nFails;

    audio_sfx_sequencer #(
        .NUM_SFX   (NUM_SFX),
        .CLK_DIV   (CLK_DIV),
        .SFX_START ({18'd48, 18'd32, 18'd16, 18'd0}),
        .SFX_END   ({18'd48, 18'd39, 18'd20, 18'd2})
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_trigger      (trigger),
        .o_rom_addr     (romAddr),
        .i_rom_q        (romQ),
        .o_sample       (sample),
        .o_sample_valid (sampleValid),
        .i_sample_ready (sampleReady),
        .o_busy         (busy),
        .o_active_id    (activeId),
        .o_done         (done),
        .o_underrun     (underrun)
    );

    // 100 MHz bench clock.
    always #5 clk = ~clk;

    // Synchronous sample ROM with one cycle of read latency.
    always @(posedge clk) begin
        romQ <= mem[romAddr[5:0]];
    end

    // Cycle counter used to time-stamp codec handshakes.
    always @(posedge clk) begin
        cycle++;
    end

    // Codec-side monitor. It samples on the falling edge, between clock
    // edges. It logs every accepted sample and counts done pulses per clip.
    // It also notes any sample that changes, or is withdrawn, before the
    // codec has taken it.
    always @(negedge clk) begin
        acc_t e;
        if (reset) begin
            holdPending = 1'b0;
        end else begin
            if (holdPending && (!sampleValid || (sample !== heldSample))) begin
                stableErr++;
            end
            if (sampleValid && sampleReady) begin
                e.s   = sample;
                e.id  = activeId;
                e.cyc = cycle;
                accQ.push_back(e);
            end
            holdPending = sampleValid && !sampleReady;
            heldSample  = sample;
            for (int k = 0; k < 4; k++) begin
                if (done[k]) begin
                    doneCount[k]++;
                end
            end
        end
    end

    // Reference conversion: unsigned ROM byte to a signed sample in the top byte.
    function automatic logic [15:0] refSample(input int a);
        return {mem[a] ^ 8'h80, 8'h00};
    endfunction

    // One comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle trigger pulse.
    task automatic applyStimulus(input logic [3:0] trig);
        @(posedge clk);
        #1;
        trigger = trig;
        @(posedge clk);
        #1;
        trigger = 4'b0000;
    endtask

    // Checks that every output is at its reset value.
    task automatic checkReset(input string tag);
        checkOutput({tag, "_rom_addr"}, 32'(romAddr), 32'd0);
        checkOutput({tag, "_sample"}, 32'(sample), 32'd0);
        checkOutput({tag, "_valid"}, 32'(sampleValid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_active_id"}, 32'(activeId), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    // Records the current done counts as the baseline for the next test.
    task automatic snapBase();
        for (int k = 0; k < 4; k++) begin
            doneBase[k] = doneCount[k];
        end
    endtask

    // Waits, within a cycle budget, until every clip in mask has signalled
    // done. It can randomise codec readiness while it waits.
    task automatic waitClips(input string tag, input logic [3:0] mask, input int budget, input bit randomReady);
        bit allDone = 1'b0;
        for (int c = 0; c < budget && !allDone; c++) begin
            @(posedge clk);
            #1;
            if (randomReady) begin
                sampleReady = ($urandom_range(0, 3) != 0);
            end
            allDone = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (mask[k] && (doneCount[k] == doneBase[k])) begin
                    allDone = 1'b0;
                end
            end
        end
        checkOutput({tag, "_timeout"}, 32'(!allDone), 32'd0);
    endtask

    // Appends the first n samples of clip k to the expected stream.
    task automatic pushExpClip(input int k, input int n);
        acc_t e;
        for (int a = clipStart[k]; a < clipStart[k] + n; a++) begin
            e.s   = refSample(a);
            e.id  = 2'(k);
            e.cyc = 0;
            expQ.push_back(e);
        end
    endtask

    // Compares the handshakes logged since qStart with the expected stream.
    task automatic compareSeq(input string tag, input int qStart);
        checkOutput({tag, "_count"}, 32'(accQ.size() - qStart), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            if (qStart + i < accQ.size()) begin
                checkOutput($sformatf("%s_sample%0d", tag, i), 32'(accQ[qStart + i].s), 32'(expQ[i].s));
                checkOutput($sformatf("%s_id%0d", tag, i), 32'(accQ[qStart + i].id), 32'(expQ[i].id));
            end
        end
        expQ.delete();
    endtask

    // Directed scenarios followed by randomised multi-trigger rounds.
    initial begin
        int q0;
        int q1;
        int ur;
        bit seen;
        logic [17:0] prevAddr;
        logic [15:0] firstSample;
        logic [3:0]  mask;

        nAsserts    = 0;
        nFails      = 0;
        reset       = 1'b1;
        trigger     = 4'b0000;
        sampleReady = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
        end
        mem[0] = 8'h80;
        mem[1] = 8'hFF;
        mem[2] = 8'h00;

        #1;
        checkReset("por");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single clip 0");
        snapBase();
        q0 = accQ.size();
        applyStimulus(4'b0001);
        waitClips("t1", 4'b0001, 200, 1'b0);
        checkOutput("t1_busy_low", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t1_done_once", 32'(doneCount[0] - doneBase[0]), 32'd1);
        pushExpClip(0, 3);
        compareSeq("t1", q0);
        if (accQ.size() >= q0 + 3) begin
            checkOutput("t1_first_0000", 32'(accQ[q0].s), 32'h0000);
            checkOutput("t1_last_8000", 32'(accQ[q0 + 2].s), 32'h8000);
            checkOutput("t1_gap1", 32'(accQ[q0 + 1].cyc - accQ[q0].cyc), 32'(CLK_DIV));
            checkOutput("t1_gap2", 32'(accQ[q0 + 2].cyc - accQ[q0 + 1].cyc), 32'(CLK_DIV));
        end

        $display("[TB] simultaneous triggers 1 and 2");
        snapBase();
        q0 = accQ.size();
        applyStimulus(4'b0110);
        waitClips("t2", 4'b0110, 400, 1'b0);
        pushExpClip(1, 5);
        pushExpClip(2, 8);
        compareSeq("t2", q0);
        checkOutput("t2_done1", 32'(doneCount[1] - doneBase[1]), 32'd1);
        checkOutput("t2_done2", 32'(doneCount[2] - doneBase[2]), 32'd1);
        checkOutput("t2_busy_low", 32'(busy), 32'd0);

        $display("[TB] clip 0 preempts clip 2");
        snapBase();
        q0 = accQ.size();
        applyStimulus(4'b0100);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = (accQ.size() >= q0 + 3);
        end
        checkOutput("t3_three_samples_timeout", 32'(!seen), 32'd0);
        applyStimulus(4'b0001);
        prevAddr = romAddr;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = (romAddr !== prevAddr);
        end
        checkOutput("t3_addr_change_timeout", 32'(!seen), 32'd0);
        checkOutput("t3_rom_addr_start0", 32'(romAddr), 32'(clipStart[0]));
        checkOutput("t3_active_id0", 32'(activeId), 32'd0);
        waitClips("t3", 4'b0001, 200, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        pushExpClip(2, 4);
        pushExpClip(0, 3);
        compareSeq("t3", q0);
        checkOutput("t3_done2_never", 32'(doneCount[2] - doneBase[2]), 32'd0);
        checkOutput("t3_done0_once", 32'(doneCount[0] - doneBase[0]), 32'd1);
        checkOutput("t3_busy_low", 32'(busy), 32'd0);

        $display("[TB] codec stall and underrun");
        sampleReady = 1'b0;
        snapBase();
        q0 = accQ.size();
        applyStimulus(4'b0100);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = sampleValid;
        end
        checkOutput("t4_valid_timeout", 32'(!seen), 32'd0);
        firstSample = sample;
        ur = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (underrun) begin
                ur++;
            end
        end
        checkOutput("t4_underrun_2to3", 32'((ur >= 2) && (ur <= 3)), 32'd1);
        checkOutput("t4_valid_held", 32'(sampleValid), 32'd1);
        checkOutput("t4_sample_held", 32'(sample), 32'(firstSample));
        checkOutput("t4_first_sample", 32'(firstSample), 32'(refSample(clipStart[2])));
        sampleReady = 1'b1;
        waitClips("t4", 4'b0100, 400, 1'b0);
        pushExpClip(2, 8);
        compareSeq("t4", q0);

        $display("[TB] zero-length clip 3");
        snapBase();
        q0 = accQ.size();
        applyStimulus(4'b1000);
        waitClips("t5", 4'b1000, 200, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        pushExpClip(3, 1);
        compareSeq("t5", q0);
        checkOutput("t5_done3_once", 32'(doneCount[3] - doneBase[3]), 32'd1);

        $display("[TB] reset in the middle of clip 1");
        snapBase();
        q0 = accQ.size();
        applyStimulus(4'b0010);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = (accQ.size() >= q0 + 2);
        end
        checkOutput("t6_two_samples_timeout", 32'(!seen), 32'd0);
        reset = 1'b1;
        #1;
        checkReset("midclip");
        @(posedge clk);
        #1;
        trigger = 4'b0100;
        @(posedge clk);
        #1;
        trigger = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q1 = accQ.size();
        repeat (30) @(posedge clk);
        #1;
        checkOutput("t6_busy_low", 32'(busy), 32'd0);
        checkOutput("t6_no_samples", 32'(accQ.size() - q1), 32'd0);
        checkOutput("t6_no_done1", 32'(doneCount[1] - doneBase[1]), 32'd0);
        checkOutput("t6_no_done2", 32'(doneCount[2] - doneBase[2]), 32'd0);

        $display("[TB] randomised trigger masks with random codec stalls");
        for (int r = 0; r < 6; r++) begin
            mask = 4'($urandom_range(1, 15));
            snapBase();
            q0 = accQ.size();
            applyStimulus(mask);
            waitClips($sformatf("rnd%0d", r), mask, 1500, 1'b1);
            sampleReady = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) begin
                    pushExpClip(k, clipEnd[k] - clipStart[k] + 1);
                end
                checkOutput($sformatf("rnd%0d_done%0d", r, k), 32'(doneCount[k] - doneBase[k]), 32'(mask[k]));
            end
            compareSeq($sformatf("rnd%0d", r), q0);
        end

        checkOutput("sample_stable", 32'(stableErr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/audio_sfx_sequencer.md
AUDIO_SFX_SEQUENCER -- requirements
Module: audio_sfx_sequencer

Interface
REQ-001 SHALL have parameter NUM_SFX, default 4, number of sound-effect clips / trigger inputs.
REQ-002 SHALL have parameter CLK_DIV, default 6250, clk cycles per output sample (50 MHz / 8 kHz).
REQ-003 SHALL have parameter SFX_START, default {18'h18000,18'h0C000,18'h06000,18'h00000}, packed 18-bit first-sample addresses; clip i at bits [18i+17:18i].
REQ-004 SHALL have parameter SFX_END, default {18'h23FFF,18'h17FFF,18'h0BFFF,18'h05FFF}, packed 18-bit last-sample addresses (inclusive), same packing.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 trigger  input  NUM_SFX  one-cycle request pulse per clip.
REQ-008 rom_addr  output  18  registered address to the 1-cycle-latency synchronous sample ROM.
REQ-009 rom_q  input  8  unsigned ROM data, valid the cycle after rom_addr is presented.
REQ-010 sample  output  16  signed sample to codec.
REQ-011 sample_valid  output  1  sample holds a new value.
REQ-012 sample_ready  input  1  codec accepts sample when high with sample_valid.
REQ-013 busy  output  1  a clip is playing.
REQ-014 active_id  output  clog2(NUM_SFX)  index of the playing clip.
REQ-015 done  output  NUM_SFX  one-cycle pulse on bit i when clip i's last sample is accepted.
REQ-016 underrun  output  1  one-cycle pulse when a sample tick arrives while a sample is still unaccepted.

Function
REQ-017 SHALL run a free-running tick counter 0..CLK_DIV-1; tick asserted for one cycle when counter = CLK_DIV-1.
REQ-018 SHALL latch every trigger bit into a pending register; pending[i] clears when clip i starts.
REQ-019 SHALL use fixed priority: lowest index wins.
REQ-020 States: IDLE, PACE, FETCH, READ, OUT.
REQ-021 IDLE: if any pending, load cur_addr = SFX_START[sel], active_id = sel, clear pending[sel], busy=1, go PACE.
REQ-022 PACE: on tick, drive rom_addr = cur_addr, go FETCH.
REQ-023 FETCH: hold rom_addr one cycle, go READ.
REQ-024 READ: sample <= {rom_q ^ 8'h80, 8'h00}; sample_valid <= 1; go OUT.
REQ-025 OUT: on sample_valid && sample_ready, drop sample_valid; if cur_addr == SFX_END[active_id], pulse done[active_id], go IDLE (busy=0 unless pending); else cur_addr+1, go PACE.
REQ-026 Tick in FETCH, READ or OUT SHALL pulse underrun and be otherwise ignored; sample held, no skip.
REQ-027 Preemption: pending[j] with j < active_id seen at an OUT acceptance SHALL start clip j (as IDLE entry) instead of advancing; current clip aborted without done.
REQ-028 Trigger of the active clip SHALL set pending and restart that clip only when the current clip ends or is preempted; no self-preemption.
REQ-029 Trigger and pending-clear of the same bit in one cycle: pending stays set.
REQ-030 rom_addr SHALL be 18-bit; cur_addr never wraps (stops at SFX_END).
REQ-031 Zero-length clip (START == END) SHALL play exactly one sample.
REQ-032 sample_valid SHALL stay high and sample stable until accepted.

Reset
REQ-033 Reset SHALL force: state IDLE, tick counter 0, pending 0, rom_addr 0, sample 0, sample_valid 0, busy 0, active_id 0, done 0, underrun 0.
REQ-034 Reset mid-clip SHALL abort immediately; no done pulse; triggers during reset ignored.

Verification
REQ-035 CLK_DIV=4, sample_ready=1, SFX_START[0]=0, SFX_END[0]=2, ROM[0..2]=80,FF,00: trigger[0] -> samples 0000,7F00,8000, one per 4 cycles, done[0] once after third, busy low.
REQ-036 trigger=4'b0110 same cycle -> clip 1 plays fully, then clip 2; active_id 1 then 2.
REQ-037 Clip 2 playing, trigger[0] -> after next acceptance rom_addr = SFX_START[0], active_id 0, done[2] never pulses.
REQ-038 sample_ready low 10 cycles with CLK_DIV=4 -> underrun pulses 2-3 times, sample stable, cur_addr not advanced.
REQ-039 Reset asserted mid-clip -> all outputs zero same cycle, state IDLE after release, pending cleared.
REQ-040 START==END clip -> exactly one sample_valid handshake, then done.
